ps2_cmd_decoder: RTL and testbench
==================================

Name: ps2_cmd_decoder

Overview:
- Sits directly downstream of the ps2 receiver.
- Consumes received scan-code bytes and tracks make, break (F0) and extended (E0) prefixes.
- Maps the five game keys to 3-bit commands and presents each new key press as a command with a valid/ready handshake to the game control logic.
- Also exports a held-key mask for continuous-motion logic.

Parameters:
- PREFIX_TIMEOUT, 50000, cycles after an F0/E0 prefix with no following byte before the decoder abandons the sequence (1 ms at 50 MHz).
- REPEAT_EN, 0, 1 = typematic repeats of a held key emit commands; 0 = only the first make emits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- byte_in  input  8  scan-code byte from ps2 receiver, valid only with byte_valid
- byte_valid  input  1  one-cycle strobe, byte_in holds a complete frame
- cmd  output  3  command code: w=3'b011, a=3'b010, s=3'b001, d=3'b000, rst=3'b100
- cmd_valid  output  1  cmd holds an unconsumed command
- cmd_ready  input  1  consumer accepts cmd when cmd_valid & cmd_ready
- held  output  5  held-key mask, bit index = {rst,w,a,s,d} → [4:0]
- overflow  output  1  one-cycle pulse, a command was dropped

Behaviour:
- Reset values:
  - cmd = 3'b000, cmd_valid = 0, held = 5'b0, overflow = 0
  - FSM = IDLE, timeout counter = 0
  - Reset mid-sequence discards any pending prefix and command.
- Key map, byte → command:
  - 0x75 → 011, 0x6B → 010, 0x72 → 001, 0x74 → 000, 0x29 → 100
  - Same mapping with or without a preceding E0.
  - All other codes are unmapped: consumed, no output effect.
- FSM states and transitions (only on byte_valid, except timeout):
  - IDLE: E0 → EXT; F0 → BRK; mapped code → MAKE action; other → IDLE.
  - EXT: F0 → BRK; mapped → MAKE action, → IDLE; other → IDLE.
  - BRK: mapped → clear held bit, → IDLE, no command; other → IDLE.
  - E0 received in BRK, or E0 received in EXT: stay/enter EXT.
- Timeout:
  - Counter runs in EXT/BRK and clears on every byte_valid.
  - Reaching PREFIX_TIMEOUT-1 → IDLE; the next byte is decoded as a fresh sequence.
- MAKE action:
  - If the key's held bit is 0, or REPEAT_EN = 1: request a command. Held bit is set in every case.
- Latency:
  - byte_valid at cycle N → cmd/cmd_valid/held updated at N+1.
- Handshake:
  - cmd_valid stays high and cmd stays stable until cmd_valid & cmd_ready.
  - The accept cycle clears cmd_valid at the next edge, unless a new request arrives in that same cycle: the new cmd is loaded and cmd_valid stays 1, with no overflow.
- Overflow:
  - A request while cmd_valid = 1 and cmd_ready = 0 drops the new command, keeps the old one, and pulses overflow for 1 cycle.
  - held still updates.
- byte_valid pulses on consecutive cycles are each processed; no back-pressure toward the receiver.

Decomposition:
- Shared package ps2_pkg:
  - scan-code constants SC_W/SC_A/SC_S/SC_D/SC_RST, SC_BREAK = 8'hF0, SC_EXT = 8'hE0
  - 3-bit command constants CMD_W/CMD_A/CMD_S/CMD_D/CMD_RST
  - FSM state encoding IDLE/EXT/BRK
- One natural sub-module: ps2_keymap, combinational byte → {hit, cmd, held index}.
- FSM, timeout counter and the output register stay in the top.

Test Plan:
- Reset, then byte 0x75, cmd_ready = 1 → cmd = 011, cmd_valid = 1 for exactly 1 cycle at N+1; held = 5'b01000.
- Bytes 0x75, F0, 0x75 → one command 011; after the break, held = 0 and no second cmd_valid.
- E0, 0x6B then E0, F0, 0x6B → cmd 010 once; held bit 2 set then cleared; unmapped 0x1C produces nothing.
- REPEAT_EN = 0: 0x72 ×3 → one cmd 001. REPEAT_EN = 1: same stimulus → three handshakes of 001.
- cmd_ready = 0: 0x74 then 0x29 → cmd stays 000, overflow pulses once on the 0x29 request. Raise cmd_ready together with a new 0x29 request → 100 loaded, no overflow.
- F0, then idle for PREFIX_TIMEOUT cycles, then 0x72 → treated as make, cmd 001. Also assert rst between E0 and 0x75 → the 0x75 decodes from IDLE with all outputs at reset values first.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 command decoder.
//   - scan codes of the five game keys plus the break (F0) and extended (E0) prefixes
//   - 3-bit command codes presented to the game control logic
//   - decoder FSM state encoding
package ps2_pkg;

  localparam logic [7:0] SC_W     = 8'h75;
  localparam logic [7:0] SC_A     = 8'h6B;
  localparam logic [7:0] SC_S     = 8'h72;
  localparam logic [7:0] SC_D     = 8'h74;
  localparam logic [7:0] SC_RST   = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [2:0] CMD_W   = 3'b011;
  localparam logic [2:0] CMD_A   = 3'b010;
  localparam logic [2:0] CMD_S   = 3'b001;
  localparam logic [2:0] CMD_D   = 3'b000;
  localparam logic [2:0] CMD_RST = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    BRK  = 2'd2
  } ps2_state_t;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code lookup for the five game keys.
//   code_in  : received scan-code byte (prefixes already stripped by the caller)
//   hit      : code_in is one of the game keys
//   cmd      : command code for that key
//   held_idx : bit position of that key in the held-key mask
// The held mask is ordered {rst,w,a,s,d}, which makes held_idx numerically
// equal to the command code; both are still produced so the top does not
// depend on that coincidence.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0] code_in,
  output logic       hit,
  output logic [2:0] cmd,
  output logic [2:0] held_idx
);

  always_comb begin
    hit      = 1'b0;
    cmd      = CMD_D;
    held_idx = 3'd0;
    case (code_in)
      SC_W:   begin hit = 1'b1; cmd = CMD_W;   held_idx = 3'd3; end
      SC_A:   begin hit = 1'b1; cmd = CMD_A;   held_idx = 3'd2; end
      SC_S:   begin hit = 1'b1; cmd = CMD_S;   held_idx = 3'd1; end
      SC_D:   begin hit = 1'b1; cmd = CMD_D;   held_idx = 3'd0; end
      SC_RST: begin hit = 1'b1; cmd = CMD_RST; held_idx = 3'd4; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code to game-command decoder.
//   clk, rst   : system clock, synchronous active-high reset
//   byte_in    : scan-code byte, qualified by the one-cycle byte_valid strobe
//   cmd        : 3-bit command, held stable while cmd_valid and not accepted
//   cmd_valid  : cmd holds an unconsumed command
//   cmd_ready  : consumer accepts cmd when cmd_valid & cmd_ready
//   held       : held-key mask {rst,w,a,s,d}
//   overflow   : one-cycle pulse when a new command had to be dropped
//
// state | meaning
// IDLE  | no prefix pending, next byte starts a sequence
// EXT   | E0 seen, waiting for the key code or F0
// BRK   | F0 seen, next mapped code releases that key
module ps2_cmd_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 50000,
  parameter bit          REPEAT_EN      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [4:0] held,
  output logic       overflow
);

  localparam int unsigned CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  ps2_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [4:0]       held_q, held_d;
  logic             overflow_q, overflow_d;

  logic       km_hit;
  logic [2:0] km_cmd;
  logic [2:0] km_idx;
  logic       make_evt;
  logic       break_evt;
  logic       req;

  ps2_keymap u_keymap (
    .code_in  (byte_in),
    .hit      (km_hit),
    .cmd      (km_cmd),
    .held_idx (km_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    overflow_d  = 1'b0;
    make_evt    = 1'b0;
    break_evt   = 1'b0;
    req         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (byte_valid) begin
          if (byte_in == SC_EXT) begin
            state_d = EXT;
          end else if (byte_in == SC_BREAK) begin
            state_d = BRK;
          end else begin
            make_evt = km_hit;
          end
        end
      end
      EXT, BRK: begin
        if (byte_valid) begin
          cnt_d = '0;
          if (byte_in == SC_EXT) begin
            state_d = EXT;
          end else if ((byte_in == SC_BREAK) && (state_q == EXT)) begin
            state_d = BRK;
          end else begin
            state_d = IDLE;
            if (state_q == EXT) begin
              make_evt = km_hit;
            end else begin
              break_evt = km_hit;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          // Orphaned prefix: abandon it so the next byte starts fresh.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (make_evt) begin
      held_d[km_idx] = 1'b1;
      req = !held_q[km_idx] || (REPEAT_EN != 1'b0);
    end
    if (break_evt) begin
      held_d[km_idx] = 1'b0;
    end

    // A request in the accept cycle replaces the consumed command directly.
    if (req) begin
      if (!cmd_valid_q || cmd_ready) begin
        cmd_d       = km_cmd;
        cmd_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= CMD_D;
      cmd_valid_q <= 1'b0;
      held_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      held_q      <= held_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign held      = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
module tb_ps2_cmd_decoder;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       cmd_ready;

  logic [2:0] cmd0, cmd1;
  logic       cmd_valid0, cmd_valid1;
  logic [4:0] held0, held1;
  logic       overflow0, overflow1;

  int assertions = 0;
  int failures   = 0;
  int hs0 = 0;
  int hs1 = 0;
  int ov0 = 0;
  bit chk1 = 1'b0;

  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];

  always #5 clk = ~clk;

  ps2_cmd_decoder #(.PREFIX_TIMEOUT(TO), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .cmd(cmd0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready),
    .held(held0), .overflow(overflow0)
  );

  ps2_cmd_decoder #(.PREFIX_TIMEOUT(TO), .REPEAT_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .cmd(cmd1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready),
    .held(held1), .overflow(overflow1)
  );

  // Scoreboard side: each accepted handshake pops the next expected command.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && cmd_valid0 && cmd_ready) begin
      hs0++;
      assertions++;
      if (exp_q0.size() == 0) begin
        failures++;
        $display("FAIL hs0_unexpected: got cmd %b, required no handshake", cmd0);
      end else begin
        e = exp_q0.pop_front();
        if (cmd0 !== e) begin
          failures++;
          $display("FAIL hs0_cmd: got %b, required %b", cmd0, e);
        end
      end
    end
    if (!rst && overflow0) ov0++;
    if (!rst && cmd_valid1 && cmd_ready) begin
      hs1++;
      if (chk1) begin
        assertions++;
        if (exp_q1.size() == 0) begin
          failures++;
          $display("FAIL hs1_unexpected: got cmd %b, required no handshake", cmd1);
        end else begin
          e = exp_q1.pop_front();
          if (cmd1 !== e) begin
            failures++;
            $display("FAIL hs1_cmd: got %b, required %b", cmd1, e);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    assertions++;
    if (cmd0 !== 3'b000) begin failures++; $display("FAIL reset_cmd: got %b, required 000", cmd0); end
    assertions++;
    if (cmd_valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", cmd_valid0); end
    assertions++;
    if (held0 !== 5'b0) begin failures++; $display("FAIL reset_held: got %b, required 00000", held0); end
    assertions++;
    if (overflow0 !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b, required 0", overflow0); end
    rst = 1'b0;
  endtask

  task automatic test_single_make();
    do_reset();
    cmd_ready = 1'b1;
    exp_q0.push_back(3'b011);
    assertions++;
    if (cmd_valid0 !== 1'b0) begin failures++; $display("FAIL single_pre_valid: got %b, required 0", cmd_valid0); end
    send(8'h75);
    assertions++;
    if (cmd_valid0 !== 1'b1) begin failures++; $display("FAIL single_valid: got %b, required 1", cmd_valid0); end
    assertions++;
    if (cmd0 !== 3'b011) begin failures++; $display("FAIL single_cmd: got %b, required 011", cmd0); end
    assertions++;
    if (held0 !== 5'b01000) begin failures++; $display("FAIL single_held: got %b, required 01000", held0); end
    idle(1);
    assertions++;
    if (cmd_valid0 !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %b, required 0", cmd_valid0); end
  endtask

  task automatic test_break();
    int h;
    do_reset();
    cmd_ready = 1'b1;
    h = hs0;
    exp_q0.push_back(3'b011);
    send(8'h75);
    send(8'hF0);
    send(8'h75);
    assertions++;
    if (held0 !== 5'b0) begin failures++; $display("FAIL break_held: got %b, required 00000", held0); end
    assertions++;
    if (cmd_valid0 !== 1'b0) begin failures++; $display("FAIL break_valid: got %b, required 0", cmd_valid0); end
    idle(2);
    assertions++;
    if (hs0 - h != 1) begin failures++; $display("FAIL break_hs_count: got %0d, required 1", hs0 - h); end
  endtask

  task automatic test_extended();
    do_reset();
    cmd_ready = 1'b1;
    exp_q0.push_back(3'b010);
    send(8'hE0);
    send(8'h6B);
    assertions++;
    if (held0 !== 5'b00100) begin failures++; $display("FAIL ext_held_set: got %b, required 00100", held0); end
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    assertions++;
    if (held0 !== 5'b0) begin failures++; $display("FAIL ext_held_clr: got %b, required 00000", held0); end
    send(8'h1C);
    idle(2);
    assertions++;
    if (held0 !== 5'b0) begin failures++; $display("FAIL ext_unmapped_held: got %b, required 00000", held0); end
    assertions++;
    if (cmd_valid0 !== 1'b0) begin failures++; $display("FAIL ext_unmapped_valid: got %b, required 0", cmd_valid0); end
    assertions++;
    if (exp_q0.size() != 0) begin failures++; $display("FAIL ext_pending: got %0d, required 0", exp_q0.size()); end
  endtask

  task automatic test_repeat();
    int h0;
    int h1;
    do_reset();
    cmd_ready = 1'b1;
    chk1 = 1'b1;
    h0 = hs0;
    h1 = hs1;
    exp_q0.push_back(3'b001);
    for (int i = 0; i < 3; i++) exp_q1.push_back(3'b001);
    for (int i = 0; i < 3; i++) send(8'h72);
    idle(3);
    chk1 = 1'b0;
    assertions++;
    if (hs0 - h0 != 1) begin failures++; $display("FAIL rep0_hs_count: got %0d, required 1", hs0 - h0); end
    assertions++;
    if (hs1 - h1 != 3) begin failures++; $display("FAIL rep1_hs_count: got %0d, required 3", hs1 - h1); end
    assertions++;
    if (held1 !== 5'b00010) begin failures++; $display("FAIL rep1_held: got %b, required 00010", held1); end
    assertions++;
    if (exp_q1.size() != 0) begin failures++; $display("FAIL rep1_pending: got %0d, required 0", exp_q1.size()); end
  endtask

  task automatic test_overflow();
    int o;
    do_reset();
    cmd_ready = 1'b0;
    o = ov0;
    exp_q0.push_back(3'b000);
    send(8'h74);
    assertions++;
    if (cmd_valid0 !== 1'b1 || cmd0 !== 3'b000) begin failures++; $display("FAIL ovf_first: got valid %b cmd %b, required 1 000", cmd_valid0, cmd0); end
    send(8'h29);
    assertions++;
    if (overflow0 !== 1'b1) begin failures++; $display("FAIL ovf_pulse: got %b, required 1", overflow0); end
    assertions++;
    if (cmd0 !== 3'b000) begin failures++; $display("FAIL ovf_cmd_kept: got %b, required 000", cmd0); end
    assertions++;
    if (held0 !== 5'b10001) begin failures++; $display("FAIL ovf_held: got %b, required 10001", held0); end
    idle(1);
    assertions++;
    if (overflow0 !== 1'b0) begin failures++; $display("FAIL ovf_pulse_end: got %b, required 0", overflow0); end
    send(8'hF0);
    send(8'h29);
    assertions++;
    if (held0 !== 5'b00001) begin failures++; $display("FAIL ovf_release: got %b, required 00001", held0); end
    exp_q0.push_back(3'b100);
    cmd_ready = 1'b1;
    send(8'h29);
    assertions++;
    if (cmd_valid0 !== 1'b1 || cmd0 !== 3'b100) begin failures++; $display("FAIL ovf_reload: got valid %b cmd %b, required 1 100", cmd_valid0, cmd0); end
    assertions++;
    if (overflow0 !== 1'b0) begin failures++; $display("FAIL ovf_reload_ovf: got %b, required 0", overflow0); end
    idle(2);
    assertions++;
    if (ov0 - o != 1) begin failures++; $display("FAIL ovf_count: got %0d, required 1", ov0 - o); end
    assertions++;
    if (cmd_valid0 !== 1'b0) begin failures++; $display("FAIL ovf_drain: got %b, required 0", cmd_valid0); end
  endtask

  task automatic test_timeout();
    do_reset();
    cmd_ready = 1'b1;
    // Still inside the prefix window: the code is a release.
    send(8'hF0);
    idle(TO - 2);
    send(8'h72);
    assertions++;
    if (cmd_valid0 !== 1'b0 || held0 !== 5'b0) begin failures++; $display("FAIL to_early: got valid %b held %b, required 0 00000", cmd_valid0, held0); end
    // Prefix abandoned: the code is a fresh make.
    send(8'hF0);
    idle(TO);
    exp_q0.push_back(3'b001);
    send(8'h72);
    assertions++;
    if (cmd_valid0 !== 1'b1 || cmd0 !== 3'b001) begin failures++; $display("FAIL to_make: got valid %b cmd %b, required 1 001", cmd_valid0, cmd0); end
    assertions++;
    if (held0 !== 5'b00010) begin failures++; $display("FAIL to_held: got %b, required 00010", held0); end
    idle(2);
  endtask

  task automatic test_reset_mid_seq();
    do_reset();
    cmd_ready = 1'b0;
    send(8'h74);
    send(8'hF0);
    rst = 1'b1;
    idle(1);
    assertions++;
    if (cmd_valid0 !== 1'b0 || held0 !== 5'b0 || cmd0 !== 3'b000 || overflow0 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: got cmd %b valid %b held %b ovf %b, required 000 0 00000 0", cmd0, cmd_valid0, held0, overflow0);
    end
    rst = 1'b0;
    cmd_ready = 1'b1;
    send(8'hE0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q0.push_back(3'b011);
    send(8'h75);
    assertions++;
    if (cmd_valid0 !== 1'b1 || cmd0 !== 3'b011 || held0 !== 5'b01000) begin
      failures++;
      $display("FAIL rstmid_make: got valid %b cmd %b held %b, required 1 011 01000", cmd_valid0, cmd0, held0);
    end
    idle(2);
  endtask

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    cmd_ready  = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_make();
    test_break();
    test_extended();
    test_repeat();
    test_overflow();
    test_timeout();
    test_reset_mid_seq();
    assertions++;
    if (exp_q0.size() != 0) begin failures++; $display("FAIL final_pending: got %0d, required 0", exp_q0.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
